// File: rtl/mfcc_seq_if.sv
// Control/status bundle between the MFCC pipeline sequencer and its environment.
// Audio handshake: a sample transfers on a rising edge where audio_valid and audio_ready are both 1.
interface mfcc_seq_if;
  logic        start;
  logic        abort;
  logic        continuous;
  logic        audio_valid;
  logic        frame_valid;
  logic        fft_valid;
  logic        mel_valid;
  logic        mfcc_valid;
  logic        audio_ready;
  logic        frame_en;
  logic        fft_en;
  logic        mel_en;
  logic        dct_en;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame_count;
  logic        overrun;
  logic        timeout_err;
  logic [2:0]  state;

  modport master (
    output start, abort, continuous, audio_valid,
    output frame_valid, fft_valid, mel_valid, mfcc_valid,
    input  audio_ready, frame_en, fft_en, mel_en, dct_en,
    input  busy, frame_done, frame_count, overrun, timeout_err, state
  );

  modport slave (
    input  start, abort, continuous, audio_valid,
    input  frame_valid, fft_valid, mel_valid, mfcc_valid,
    output audio_ready, frame_en, fft_en, mel_en, dct_en,
    output busy, frame_done, frame_count, overrun, timeout_err, state
  );
endinterface

// File: rtl/mfcc_sequencer.sv
// Steps framing -> FFT -> mel filter -> log/DCT by counting each stage's valid beats,
// with a per-stage watchdog, sticky overrun/timeout flags and a completed-frame counter.
module mfcc_sequencer #(
  parameter int FRAME_SIZE  = 8,
  parameter int FFT_SIZE    = 8,
  parameter int NUM_FILTERS = 4,
  parameter int NUM_CEPS    = 8,
  parameter int TIMEOUT     = 64
) (
  input  logic       clk,
  input  logic       rst,
  mfcc_seq_if.slave  bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FRAME = 3'd1;
  localparam logic [2:0] S_FFT   = 3'd2;
  localparam logic [2:0] S_MEL   = 3'd3;
  localparam logic [2:0] S_DCT   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;
  localparam logic [2:0] S_ERROR = 3'd6;

  localparam logic [15:0] FRAME_N   = 16'(FRAME_SIZE);
  localparam logic [15:0] FFT_N     = 16'(FFT_SIZE);
  localparam logic [15:0] FILT_N    = 16'(NUM_FILTERS);
  localparam logic [15:0] CEPS_N    = 16'(NUM_CEPS);
  localparam logic [15:0] TIMEOUT_N = 16'(TIMEOUT);

  logic [2:0]  state_q, state_d;
  logic [15:0] beat_q, beat_d;
  logic [15:0] audio_cnt_q, audio_cnt_d;
  logic [15:0] wdog_q, wdog_d;
  logic [15:0] count_q, count_d;
  logic        overrun_q, overrun_d;
  logic        timeout_q, timeout_d;
  logic        audio_ready_q, audio_ready_d;
  logic        frame_en_q, frame_en_d;
  logic        fft_en_q, fft_en_d;
  logic        mel_en_q, mel_en_d;
  logic        dct_en_q, dct_en_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;

  logic        beat_hit;
  logic [15:0] beat_target;
  logic        audio_accept;
  logic        ovr_set;

  assign audio_accept = bus.audio_valid & audio_ready_q;
  assign ovr_set      = bus.audio_valid & ~audio_ready_q & busy_q;

  // Only the valid of the stage owning the current state counts as a beat.
  always_comb begin
    beat_hit    = 1'b0;
    beat_target = FRAME_N;
    case (state_q)
      S_FRAME: begin beat_hit = bus.frame_valid; beat_target = FRAME_N; end
      S_FFT:   begin beat_hit = bus.fft_valid;   beat_target = FFT_N;   end
      S_MEL:   begin beat_hit = bus.mel_valid;   beat_target = FILT_N;  end
      S_DCT:   begin beat_hit = bus.mfcc_valid;  beat_target = CEPS_N;  end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    audio_cnt_d = audio_cnt_q;
    wdog_d      = wdog_q;
    count_d     = count_q;
    overrun_d   = overrun_q | ovr_set;
    timeout_d   = timeout_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          state_d     = S_FRAME;
          beat_d      = '0;
          audio_cnt_d = '0;
          wdog_d      = '0;
          overrun_d   = 1'b0;
        end
      end
      S_FRAME, S_FFT, S_MEL, S_DCT: begin
        if (audio_accept) audio_cnt_d = audio_cnt_q + 16'd1;
        // A beat landing on the watchdog's last cycle still counts and rearms it.
        if (beat_hit) begin
          wdog_d = '0;
          if (beat_q == beat_target - 16'd1) begin
            state_d = state_q + 3'd1;
            beat_d  = '0;
            if (state_q == S_DCT) count_d = count_q + 16'd1;
          end else begin
            beat_d = beat_q + 16'd1;
          end
        end else if (wdog_q == TIMEOUT_N - 16'd1) begin
          state_d   = S_ERROR;
          timeout_d = 1'b1;
          beat_d    = '0;
          wdog_d    = '0;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
      end
      S_DONE: begin
        beat_d      = '0;
        audio_cnt_d = '0;
        wdog_d      = '0;
        state_d     = bus.continuous ? S_FRAME : S_IDLE;
      end
      S_ERROR: begin
        if (bus.start) begin
          state_d     = S_FRAME;
          beat_d      = '0;
          audio_cnt_d = '0;
          wdog_d      = '0;
          timeout_d   = 1'b0;
          overrun_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Abort overrides everything above but keeps the frame count and sticky flags.
    if (bus.abort) begin
      state_d     = S_IDLE;
      beat_d      = '0;
      audio_cnt_d = '0;
      wdog_d      = '0;
      count_d     = count_q;
      timeout_d   = timeout_q;
      overrun_d   = overrun_q | ovr_set;
    end
  end

  always_comb begin
    frame_en_d    = (state_d == S_FRAME);
    fft_en_d      = (state_d == S_FFT);
    mel_en_d      = (state_d == S_MEL);
    dct_en_d      = (state_d == S_DCT);
    audio_ready_d = (state_d == S_FRAME) && (audio_cnt_d < FRAME_N);
    busy_d        = (state_d != S_IDLE) && (state_d != S_ERROR);
    frame_done_d  = (state_d == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= S_IDLE;
      beat_q        <= '0;
      audio_cnt_q   <= '0;
      wdog_q        <= '0;
      count_q       <= '0;
      overrun_q     <= 1'b0;
      timeout_q     <= 1'b0;
      audio_ready_q <= 1'b0;
      frame_en_q    <= 1'b0;
      fft_en_q      <= 1'b0;
      mel_en_q      <= 1'b0;
      dct_en_q      <= 1'b0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
    end else begin
      state_q       <= state_d;
      beat_q        <= beat_d;
      audio_cnt_q   <= audio_cnt_d;
      wdog_q        <= wdog_d;
      count_q       <= count_d;
      overrun_q     <= overrun_d;
      timeout_q     <= timeout_d;
      audio_ready_q <= audio_ready_d;
      frame_en_q    <= frame_en_d;
      fft_en_q      <= fft_en_d;
      mel_en_q      <= mel_en_d;
      dct_en_q      <= dct_en_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
    end
  end

  assign bus.state       = state_q;
  assign bus.audio_ready = audio_ready_q;
  assign bus.frame_en    = frame_en_q;
  assign bus.fft_en      = fft_en_q;
  assign bus.mel_en      = mel_en_q;
  assign bus.dct_en      = dct_en_q;
  assign bus.busy        = busy_q;
  assign bus.frame_done  = frame_done_q;
  assign bus.frame_count = count_q;
  assign bus.overrun     = overrun_q;
  assign bus.timeout_err = timeout_q;

endmodule

// File: doc/mfcc_sequencer.md
MFCC_SEQUENCER -- requirements
Module: mfcc_sequencer

Interface
REQ-001 SHALL have parameter FRAME_SIZE, default 8: samples per frame and windowed beats expected from framing.
REQ-002 SHALL have parameter FFT_SIZE, default 8: fft valid_out beats per frame.
REQ-003 SHALL have parameter NUM_FILTERS, default 4: mel_filter valid_out beats per frame.
REQ-004 SHALL have parameter NUM_CEPS, default 8: log_dct valid_out beats per frame.
REQ-005 SHALL have parameter TIMEOUT, default 64: idle cycles allowed between counted beats.
REQ-006 SHALL have port clk, input, 1: single clock; all logic on rising edge.
REQ-007 SHALL have port rst, input, 1: reset, synchronous, active-low (0 = reset).
REQ-008 SHALL have port start, input, 1: arm sequencer; sampled every cycle.
REQ-009 SHALL have port abort, input, 1: return to IDLE.
REQ-010 SHALL have port continuous, input, 1: 1 = restart the next frame automatically after DONE.
REQ-011 SHALL have port audio_valid, input, 1: audio sample presented to framing.
REQ-012 SHALL have ports frame_valid, fft_valid, mel_valid, mfcc_valid, input, 1 each: valid_out of framing, fft, mel_filter and log_dct.
REQ-013 SHALL have port audio_ready, output, 1: sample accepted when audio_valid and audio_ready are both 1.
REQ-014 SHALL have ports frame_en, fft_en, mel_en, dct_en, output, 1 each: stage enables.
REQ-015 SHALL have port busy, output, 1: state not IDLE and not ERROR.
REQ-016 SHALL have port frame_done, output, 1: one-cycle pulse per completed frame.
REQ-017 SHALL have port frame_count, output, 16: completed frames.
REQ-018 SHALL have ports overrun and timeout_err, output, 1 each: sticky error flags.
REQ-019 SHALL have port state, output, 3: IDLE=0, FRAME=1, FFT=2, MEL=3, DCT=4, DONE=5, ERROR=6.

Function
REQ-020 SHALL hold all state, counters and outputs in registers; all transitions take effect on the edge after the condition is sampled.
REQ-021 IDLE: on start=1, go to FRAME; clear the beat counters, audio counter and watchdog; clear overrun.
REQ-022 FRAME: frame_en=1; audio_ready=1 while accepted samples < FRAME_SIZE; count frame_valid beats; on the FRAME_SIZE-th beat go to FFT.
REQ-023 FFT: fft_en=1; count fft_valid; on the FFT_SIZE-th beat go to MEL.
REQ-024 MEL: mel_en=1; count mel_valid; on the NUM_FILTERS-th beat go to DCT.
REQ-025 DCT: dct_en=1; count mfcc_valid; on the NUM_CEPS-th beat go to DONE.
REQ-026 Each stage enable SHALL be 1 only in its own state, so at most one enable is high in any cycle.
REQ-027 Valid inputs of non-active stages SHALL be ignored and not counted.
REQ-028 The beat counter SHALL clear on every state change.
REQ-029 DONE lasts one cycle: frame_done=1; frame_count increments, wrapping 65535 -> 0.
REQ-030 From DONE: continuous=1 -> FRAME with counters cleared; otherwise -> IDLE.
REQ-031 Watchdog: in FRAME/FFT/MEL/DCT, count cycles since the last counted beat or state entry; on reaching TIMEOUT go to ERROR and set timeout_err.
REQ-032 ERROR: all enables and audio_ready are 0; start=1 -> FRAME, clearing timeout_err and overrun.
REQ-033 overrun SHALL be set when audio_valid=1 and audio_ready=0 while busy=1; it holds until start is accepted in IDLE or ERROR, or reset.
REQ-034 abort=1 in any state -> IDLE next cycle; enables drop; frame_count and sticky flags are kept.
REQ-035 abort and start both high: abort wins.
REQ-036 start while busy SHALL be ignored.
REQ-037 A counted beat in the same cycle the watchdog reaches TIMEOUT: the beat wins, the count advances and the watchdog clears.

Reset
REQ-038 While rst=0 at a clock edge: state=IDLE, all enables, audio_ready, busy, frame_done, overrun and timeout_err = 0; frame_count=0; all counters=0.
REQ-039 Reset mid-frame SHALL abandon the frame with no frame_done pulse; rst dominates start and abort.

Verification
REQ-040 Reset then start, 8 audio and 8 frame_valid, 8 fft_valid, 4 mel_valid, 8 mfcc_valid, continuous=0 -> states 1,2,3,4,5,0 in order, one frame_done pulse, frame_count=1.
REQ-041 continuous=1, three full frames -> three frame_done pulses, frame_count=3, no IDLE visit between frames.
REQ-042 In FFT after 3 of 8 beats, no fft_valid for 64 cycles -> state=6, timeout_err=1, fft_en=0; then start -> state=1, timeout_err=0.
REQ-043 9th audio_valid in FRAME after 8 accepted -> audio_ready=0 on the 9th, overrun=1 and stays 1 through DONE.
REQ-044 abort and start high together in MEL -> state=0 next cycle, mel_en=0, frame_count unchanged.
REQ-045 frame_count preset to 65535 through 65535 continuous frames -> the next DONE gives frame_count=0; rst=0 mid-DCT -> all outputs at reset values next cycle, no frame_done.
